mac_d4_stream: RTL and testbench
================================

// Module: mac_d4_stream
// PURPOSE
// - Parametrised, backpressured D4 (Daubechies-4) analysis MAC for one 1-D pass of the 2-D DWT.
// - Consumes one line as a stream of (even, odd) pixel pairs; emits one (approx, detail) pair per input pair.
// - Periodic extension at line end; sits between the line/column sequencer and the transpose buffer.
// PARAMETERS
// - WIDTH      256    line length in pixels; PTR_W = $clog2(WIDTH)
// - PIX_W      8      bits per pixel, unsigned
// - COEF_W     16     signed coefficient width
// - COEF_FRAC  14     fractional bits of H0..H3
// - H0..H3     7913, 13706, 3672, -2120    D4 taps 0.48296, 0.83652, 0.22414, -0.12941 in Q(COEF_FRAC)
// - OUT_SHIFT  1      extra right shift applied after removing COEF_FRAC
// PORTS
// - clk                   in   1          rising-edge clock
// - rst_n                 in   1          asynchronous active-low reset
// - i_pixel               in   2*PIX_W    [2*PIX_W-1:PIX_W] = even pixel x(2n), [PIX_W-1:0] = odd pixel x(2n+1)
// - i_valid               in   1          input pair valid
// - i_ready               out  1          block accepts pair; transfer when i_valid & i_ready
// - i_last                in   1          pair is the last pair of the line
// - i_pixel_pointer       in   PTR_W      pair position in line; 0 = first pair
// - i_row_column_pointer  in   PTR_W      row/column index, passed through
// - o_pixel               out  2*PIX_W    [2*PIX_W-1:PIX_W] = approx lo[n], [PIX_W-1:0] = detail hi[n]
// - o_valid               out  1          output valid
// - o_ready               in   1          downstream accepts; transfer when o_valid & o_ready
// - o_pixel_pointer       out  PTR_W      pointer of pair n
// - o_row_column_pointer  out  PTR_W      row/column pointer of pair n
// BEHAVIOUR
// - Reset (async on rst_n low): o_valid=0, o_pixel=0, both o_*_pointer=0; FSM=EMPTY; pipeline valids cleared.
//   Reset mid-line discards the held and in-flight pairs.
// - Math (signed, full precision, ACC_W = PIX_W+COEF_W+3):
//   lo[n] = H0*x(2n) + H1*x(2n+1) + H2*x(2n+2) + H3*x(2n+3)
//   hi[n] = H3*x(2n) - H2*x(2n+1) + H1*x(2n+2) - H0*x(2n+3)
//   Result = arithmetic >>> (COEF_FRAC+OUT_SHIFT), then clamp to [0, 2^PIX_W-1]: negative -> 0, overflow -> max.
// - Periodic extension: a pair with i_pixel_pointer==0 is also stored as FIRST.
//   For the last pair of a line, x(2n+2), x(2n+3) = FIRST.
// - Window FSM:
//   EMPTY: i_ready=en. On accept: hold the pair (and its pointers) -> HOLD.
//     If i_last is also set (one-pair line), issue window (pair, pair) and stay EMPTY.
//   HOLD: i_ready=en. Accepted pair P -> issue window (held, P).
//     If P.i_last -> FLUSH, else P becomes held and state stays HOLD.
//   FLUSH: i_ready=0. Issue window (P, FIRST) for the last pair -> EMPTY (one cycle when en).
// - Pipeline: window regs -> S1 products registered -> S2 sum/shift/clamp into o_* regs.
//   Latency: window issued at edge t gives o_valid at edge t+2.
// - Stall: en = !o_valid | o_ready. When en=0 every stage, FSM and FIRST hold.
//   o_pixel and pointers stay stable while o_valid & !o_ready.
// - Bubbles are allowed; output order = pair order. The first pair of the next line may be accepted directly after FLUSH.
// - i_valid while in FLUSH is not accepted (i_ready=0); the upstream holds its data.
// CONFIGURATION
// - DETAIL_OFFSET_EN defined: before the clamp, hi[n] gets + 2^(PIX_W-1) (mid-grey bias), so negative details are kept.
// - DETAIL_OFFSET_EN undefined: hi[n] is clamped directly, so negative -> 0. lo[n] is unaffected in both builds.
// TESTING
// - Constant line: 128 pairs of (100,100), o_ready=1 -> 128 outputs lo=70, hi=0 (hi=128 with DETAIL_OFFSET_EN).
// - Wrap: 2-pair line (10,20),(30,40), second pair with i_last -> outputs (lo,hi) = (11,0) then (23,0).
//   The second output uses FIRST=(10,20). Pointers are 0 then 1.
// - Negative/clamp: line of (0,255) pairs -> lo=90, hi=0.
//   With OUT_SHIFT=0, a line of (255,255) pairs -> lo clamps to 255.
// - Backpressure: hold o_ready=0 for 5 cycles mid-line -> o_pixel/pointers stable, i_ready=0 once full.
//   No output is lost or duplicated; the output count equals the input count.
// - Back-to-back lines: i_valid held high across two 4-pair lines -> i_ready drops exactly 1 cycle per FLUSH.
//   Each line's last output uses its own FIRST pair.
// - Async reset: assert rst_n=0 mid-line between clock edges -> o_valid=0 immediately.
//   The next line after release is computed as a fresh line with no stale FIRST or held pair.

Source files
------------

// File: rtl/mac_d4_stream_if.sv
// Pixel-pair stream bundle (data, valid/ready, line-end flag and pointers) used on both sides of mac_d4_stream.
interface mac_d4_stream_if #(
    parameter int PIX_W = 8,
    parameter int PTR_W = 8
) ();
    logic [2*PIX_W-1:0] pixel;
    logic               valid;
    logic               ready;
    logic               last;
    logic [PTR_W-1:0]   pixel_pointer;
    logic [PTR_W-1:0]   row_column_pointer;

    modport master (output pixel, valid, last, pixel_pointer, row_column_pointer, input ready);
    modport slave  (input pixel, valid, last, pixel_pointer, row_column_pointer, output ready);
endinterface

// File: rtl/mac_d4_stream.sv
// D4 wavelet analysis MAC for one 1-D DWT pass: (even, odd) pairs in, (approx, detail) pairs out.
// Build option: define DETAIL_OFFSET_EN to add a mid-grey bias to the detail band before clamping.
module mac_d4_stream #(
    parameter int                       WIDTH     = 256,
    parameter int                       PIX_W     = 8,
    parameter int                       COEF_W    = 16,
    parameter int                       COEF_FRAC = 14,
    parameter logic signed [COEF_W-1:0] H0        = COEF_W'(7913),
    parameter logic signed [COEF_W-1:0] H1        = COEF_W'(13706),
    parameter logic signed [COEF_W-1:0] H2        = COEF_W'(3672),
    parameter logic signed [COEF_W-1:0] H3        = COEF_W'(-2120),
    parameter int                       OUT_SHIFT = 1,
    localparam int                      PTR_W     = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_d4_stream_if.slave  i,
    mac_d4_stream_if.master o
);

    localparam int ACC_W  = PIX_W + COEF_W + 3;
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int SHIFT  = COEF_FRAC + OUT_SHIFT;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((2 ** PIX_W) - 1);
`ifdef DETAIL_OFFSET_EN
    localparam logic signed [ACC_W-1:0] DETAIL_BIAS = ACC_W'(2 ** (PIX_W - 1));
`endif

    // Tap k multiplies window sample x(2n+k); the detail taps are the time-reversed,
    // sign-alternated approximation taps.
    function automatic logic signed [COEF_W-1:0] lo_tap(input int k);
        case (k)
            0:       lo_tap = H0;
            1:       lo_tap = H1;
            2:       lo_tap = H2;
            default: lo_tap = H3;
        endcase
    endfunction

    function automatic logic signed [COEF_W-1:0] hi_tap(input int k);
        case (k)
            0:       hi_tap = H3;
            1:       hi_tap = -H2;
            2:       hi_tap = H1;
            default: hi_tap = -H0;
        endcase
    endfunction

    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1])
            clamp_pix = '0;
        else if (v > PIX_MAX)
            clamp_pix = '1;
        else
            clamp_pix = v[PIX_W-1:0];
    endfunction

    typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;

    state_t                 state_reg, state_next;
    logic [2*PIX_W-1:0]     held_reg, first_reg;
    logic [PTR_W-1:0]       held_ptr_reg, held_row_reg;
    logic                   en, in_ready, accept, hold_load;
    logic                   issue, issue_last;
    logic [2*PIX_W-1:0]     issue_a, issue_b;
    logic [PTR_W-1:0]       issue_ptr, issue_row;

    logic                   win_valid_reg, win_last_reg;
    logic [2*PIX_W-1:0]     win_a_reg, win_b_reg;
    logic [PTR_W-1:0]       win_ptr_reg, win_row_reg;
    logic [3:0][PIX_W-1:0]  win_x;

    logic [3:0][PROD_W-1:0] lo_prod, hi_prod, lo_prod_reg, hi_prod_reg;
    logic                   s1_valid_reg, s1_last_reg;
    logic [PTR_W-1:0]       s1_ptr_reg, s1_row_reg;

    logic signed [ACC_W-1:0] lo_sum, hi_sum, lo_shift, hi_shift;

    logic                   o_valid_reg, o_last_reg;
    logic [2*PIX_W-1:0]     o_pixel_reg;
    logic [PTR_W-1:0]       o_ptr_reg, o_row_reg;

    // One global enable: the whole pipeline advances only when the output slot can move.
    assign en       = !o_valid_reg || o.ready;
    assign in_ready = (state_reg != FLUSH) && en;
    assign accept   = i.valid && in_ready;
    assign i.ready  = in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= EMPTY;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        hold_load  = 1'b0;
        issue      = 1'b0;
        issue_a    = held_reg;
        issue_b    = i.pixel;
        issue_ptr  = held_ptr_reg;
        issue_row  = held_row_reg;
        issue_last = 1'b0;
        unique case (state_reg)
            EMPTY: begin
                if (accept) begin
                    hold_load = 1'b1;
                    if (i.last) begin
                        issue      = 1'b1;
                        issue_a    = i.pixel;
                        issue_b    = i.pixel;
                        issue_ptr  = i.pixel_pointer;
                        issue_row  = i.row_column_pointer;
                        issue_last = 1'b1;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    hold_load = 1'b1;
                    issue     = 1'b1;
                    if (i.last)
                        state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Last pair of the line wraps around onto the stored first pair.
                if (en) begin
                    issue      = 1'b1;
                    issue_b    = first_reg;
                    issue_last = 1'b1;
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_reg     <= '0;
            held_ptr_reg <= '0;
            held_row_reg <= '0;
            first_reg    <= '0;
        end else begin
            if (hold_load) begin
                held_reg     <= i.pixel;
                held_ptr_reg <= i.pixel_pointer;
                held_row_reg <= i.row_column_pointer;
            end
            if (accept && (i.pixel_pointer == '0))
                first_reg <= i.pixel;
        end
    end

    assign win_x = {win_b_reg[PIX_W-1:0], win_b_reg[2*PIX_W-1:PIX_W],
                    win_a_reg[PIX_W-1:0], win_a_reg[2*PIX_W-1:PIX_W]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tap
            localparam logic signed [COEF_W-1:0] LO_C = lo_tap(gi);
            localparam logic signed [COEF_W-1:0] HI_C = hi_tap(gi);
            logic signed [PROD_W-1:0] x_ext;
            assign x_ext       = $signed({{(PROD_W-PIX_W){1'b0}}, win_x[gi]});
            assign lo_prod[gi] = x_ext * $signed({{(PROD_W-COEF_W){LO_C[COEF_W-1]}}, LO_C});
            assign hi_prod[gi] = x_ext * $signed({{(PROD_W-COEF_W){HI_C[COEF_W-1]}}, HI_C});
        end
    endgenerate

    always_comb begin
        lo_sum = '0;
        hi_sum = '0;
        for (int k = 0; k < 4; k++) begin
            lo_sum = lo_sum + ACC_W'($signed(lo_prod_reg[k]));
            hi_sum = hi_sum + ACC_W'($signed(hi_prod_reg[k]));
        end
        lo_shift = lo_sum >>> SHIFT;
        hi_shift = hi_sum >>> SHIFT;
`ifdef DETAIL_OFFSET_EN
        hi_shift = hi_shift + DETAIL_BIAS;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
            win_a_reg     <= '0;
            win_b_reg     <= '0;
            win_ptr_reg   <= '0;
            win_row_reg   <= '0;
            s1_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            s1_ptr_reg    <= '0;
            s1_row_reg    <= '0;
            lo_prod_reg   <= '0;
            hi_prod_reg   <= '0;
            o_valid_reg   <= 1'b0;
            o_last_reg    <= 1'b0;
            o_pixel_reg   <= '0;
            o_ptr_reg     <= '0;
            o_row_reg     <= '0;
        end else if (en) begin
            win_valid_reg <= issue;
            if (issue) begin
                win_a_reg    <= issue_a;
                win_b_reg    <= issue_b;
                win_ptr_reg  <= issue_ptr;
                win_row_reg  <= issue_row;
                win_last_reg <= issue_last;
            end
            s1_valid_reg <= win_valid_reg;
            if (win_valid_reg) begin
                lo_prod_reg <= lo_prod;
                hi_prod_reg <= hi_prod;
                s1_ptr_reg  <= win_ptr_reg;
                s1_row_reg  <= win_row_reg;
                s1_last_reg <= win_last_reg;
            end
            o_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                o_pixel_reg <= {clamp_pix(lo_shift), clamp_pix(hi_shift)};
                o_ptr_reg   <= s1_ptr_reg;
                o_row_reg   <= s1_row_reg;
                o_last_reg  <= s1_last_reg;
            end
        end
    end

    assign o.valid              = o_valid_reg;
    assign o.pixel              = o_pixel_reg;
    assign o.pixel_pointer      = o_ptr_reg;
    assign o.row_column_pointer = o_row_reg;
    assign o.last               = o_last_reg;

endmodule

// File: tb/tb_mac_d4_stream.sv
// Directed bench for mac_d4_stream: scoreboard of reference (approx, detail) pairs checked as outputs appear.
module tb_mac_d4_stream;
    localparam int PIX_W = 8;
    localparam int PTR_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_d4_stream_if #(.PIX_W(PIX_W), .PTR_W(PTR_W)) in_if ();
    mac_d4_stream_if #(.PIX_W(PIX_W), .PTR_W(PTR_W)) out_if ();
    mac_d4_stream_if #(.PIX_W(PIX_W), .PTR_W(PTR_W)) in2_if ();
    mac_d4_stream_if #(.PIX_W(PIX_W), .PTR_W(PTR_W)) out2_if ();

    mac_d4_stream u_dut (.clk(clk), .rst_n(rst_n), .i(in_if), .o(out_if));
    mac_d4_stream #(.OUT_SHIFT(0)) u_dut_s0 (.clk(clk), .rst_n(rst_n), .i(in2_if), .o(out2_if));
    assign out2_if.ready = 1'b1;

    typedef struct packed {
        logic [15:0] pix;
        logic [7:0]  ptr;
        logic [7:0]  row;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t sb2[$];
    int   checks = 0;
    int   failures = 0;
    int   in_cnt = 0;
    int   out_cnt = 0;
    int   nready_cnt = 0;
    bit   count_nready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] clamp8(input longint v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    // Reference D4 analysis of one window x0..x3 with the given extra output shift.
    function automatic logic [15:0] ref_pair(input int x0, input int x1, input int x2, input int x3, input int sh);
        longint lo, hi;
        lo = longint'(7913 * x0 + 13706 * x1 + 3672 * x2 - 2120 * x3);
        hi = longint'(-2120 * x0 - 3672 * x1 + 13706 * x2 - 7913 * x3);
        lo = lo >>> (14 + sh);
        hi = hi >>> (14 + sh);
`ifdef DETAIL_OFFSET_EN
        hi = hi + 128;
`endif
        return {clamp8(lo), clamp8(hi)};
    endfunction

    task automatic drive_pair(input logic [15:0] pix, input int ptr, input int row, input bit last);
        int wait_cyc;
        wait_cyc = 0;
        in_if.valid = 1'b1;
        in_if.pixel = pix;
        in_if.last = last;
        in_if.pixel_pointer = 8'(ptr);
        in_if.row_column_pointer = 8'(row);
        @(negedge clk);
        while (!in_if.ready && wait_cyc <= 200) begin
            wait_cyc++;
            @(negedge clk);
        end
        if (wait_cyc > 200) begin
            failures++;
            $error("FAIL accept_timeout ptr=%0d observed_ready=0 required_ready=1", ptr);
            in_if.valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        in_cnt++;
    endtask

    task automatic send_line(input logic [15:0] pairs[$], input int row);
        int n;
        logic [15:0] nxt;
        n = pairs.size();
        for (int k = 0; k < n; k++) begin
            nxt = (k == n - 1) ? pairs[0] : pairs[k + 1];
            sb.push_back('{pix: ref_pair(int'(pairs[k][15:8]), int'(pairs[k][7:0]),
                                         int'(nxt[15:8]), int'(nxt[7:0]), 1),
                           ptr: 8'(k), row: 8'(row), last: (k == n - 1)});
        end
        for (int k = 0; k < n; k++)
            drive_pair(pairs[k], k, row, (k == n - 1));
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((sb.size() != 0 || sb2.size() != 0) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) begin
            failures++;
            $error("FAIL drain_timeout pending=%0d required=0", sb.size() + sb2.size());
        end
        @(posedge clk);
        #1;
    endtask

    logic [15:0] prev_pix;
    logic [7:0]  prev_ptr, prev_row;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_if.valid), 32'd1);
                check("stall_pixel", 32'(out_if.pixel), 32'(prev_pix));
                check("stall_ptr", 32'(out_if.pixel_pointer), 32'(prev_ptr));
                check("stall_row", 32'(out_if.row_column_pointer), 32'(prev_row));
            end
            if (out_if.valid && out_if.ready) begin
                out_cnt++;
                $display("OUT ptr=%0d row=%0d lo=%0d hi=%0d last=%0d", out_if.pixel_pointer,
                         out_if.row_column_pointer, out_if.pixel[15:8], out_if.pixel[7:0], out_if.last);
                if (sb.size() == 0) begin
                    failures++;
                    $error("FAIL unexpected_output observed=%0h required=none", out_if.pixel);
                end else begin
                    e = sb.pop_front();
                    check("out_lo", 32'(out_if.pixel[15:8]), 32'(e.pix[15:8]));
                    check("out_hi", 32'(out_if.pixel[7:0]), 32'(e.pix[7:0]));
                    check("out_ptr", 32'(out_if.pixel_pointer), 32'(e.ptr));
                    check("out_row", 32'(out_if.row_column_pointer), 32'(e.row));
                    check("out_last", 32'(out_if.last), 32'(e.last));
                end
            end
            prev_stall = out_if.valid && !out_if.ready;
            prev_pix   = out_if.pixel;
            prev_ptr   = out_if.pixel_pointer;
            prev_row   = out_if.row_column_pointer;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out2_if.valid) begin
            $display("OUT2 ptr=%0d lo=%0d hi=%0d", out2_if.pixel_pointer, out2_if.pixel[15:8], out2_if.pixel[7:0]);
            if (sb2.size() == 0) begin
                failures++;
                $error("FAIL unexpected_output_s0 observed=%0h required=none", out2_if.pixel);
            end else begin
                e = sb2.pop_front();
                check("s0_lo", 32'(out2_if.pixel[15:8]), 32'(e.pix[15:8]));
                check("s0_hi", 32'(out2_if.pixel[7:0]), 32'(e.pix[7:0]));
                check("s0_ptr", 32'(out2_if.pixel_pointer), 32'(e.ptr));
            end
        end
    end

    always @(negedge clk)
        if (count_nready && !in_if.ready)
            nready_cnt++;

    initial begin
        logic [15:0] line[$];
        logic [15:0] line_b[$];

        in_if.valid = 1'b0;
        in_if.pixel = '0;
        in_if.last = 1'b0;
        in_if.pixel_pointer = '0;
        in_if.row_column_pointer = '0;
        in2_if.valid = 1'b0;
        in2_if.pixel = '0;
        in2_if.last = 1'b0;
        in2_if.pixel_pointer = '0;
        in2_if.row_column_pointer = '0;
        out_if.ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_valid", 32'(out_if.valid), 32'd0);
        check("rst_o_pixel", 32'(out_if.pixel), 32'd0);
        check("rst_o_ptr", 32'(out_if.pixel_pointer), 32'd0);
        check("rst_o_row", 32'(out_if.row_column_pointer), 32'd0);
        check("rst_i_ready", 32'(in_if.ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Constant line of 128 pairs
        line = {};
        for (int k = 0; k < 128; k++) line.push_back({8'd100, 8'd100});
        send_line(line, 5);

        // Two-pair line wrapping onto its first pair
        line = {16'h0a14, 16'h1e28};
        send_line(line, 6);

        // One-pair line
        line = {16'hc832};
        send_line(line, 7);

        // Negative detail clamp
        line = {};
        for (int k = 0; k < 4; k++) line.push_back({8'd0, 8'd255});
        send_line(line, 8);

        // Backpressure for 5 cycles mid-line
        line = {};
        for (int k = 0; k < 8; k++) line.push_back(16'($urandom));
        fork
            send_line(line, 9);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_if.ready = 1'b0;
                repeat (5) @(negedge clk);
                check("bp_o_valid", 32'(out_if.valid), 32'd1);
                check("bp_i_ready", 32'(in_if.ready), 32'd0);
                @(posedge clk);
                #1;
                out_if.ready = 1'b1;
            end
        join
        drain();

        // Back-to-back 4-pair lines with valid held high
        line = {};
        line_b = {};
        for (int k = 0; k < 4; k++) begin
            line.push_back(16'($urandom));
            line_b.push_back(16'($urandom));
        end
        nready_cnt = 0;
        count_nready = 1'b1;
        send_line(line, 10);
        send_line(line_b, 11);
        repeat (4) @(negedge clk);
        count_nready = 1'b0;
        check("flush_ready_drops", 32'(nready_cnt), 32'd2);
        drain();

        // Async reset mid-line with a stalled output
        out_if.ready = 1'b0;
        drive_pair(16'h1122, 0, 12, 1'b0);
        drive_pair(16'h3344, 1, 12, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_o_valid", 32'(out_if.valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_o_valid", 32'(out_if.valid), 32'd0);
        check("async_rst_o_pixel", 32'(out_if.pixel), 32'd0);
        check("async_rst_o_ptr", 32'(out_if.pixel_pointer), 32'd0);
        check("async_rst_o_row", 32'(out_if.row_column_pointer), 32'd0);
        in_cnt -= 2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_if.ready = 1'b1;
        @(posedge clk);
        #1;
        line = {16'h323c, 16'h4650};
        send_line(line, 13);
        drain();

        // Overflow clamp on the OUT_SHIFT=0 instance
        for (int k = 0; k < 2; k++)
            sb2.push_back('{pix: ref_pair(255, 255, 255, 255, 0), ptr: 8'(k), row: 8'd3, last: (k == 1)});
        for (int k = 0; k < 2; k++) begin
            in2_if.valid = 1'b1;
            in2_if.pixel = 16'hffff;
            in2_if.last = (k == 1);
            in2_if.pixel_pointer = 8'(k);
            in2_if.row_column_pointer = 8'd3;
            @(negedge clk);
            check("s0_i_ready", 32'(in2_if.ready), 32'd1);
            @(posedge clk);
            #1;
        end
        in2_if.valid = 1'b0;
        drain();

        check("scoreboard_empty", 32'(sb.size() + sb2.size()), 32'd0);
        check("io_count", 32'(out_cnt), 32'(in_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
